// File: rtl/dshot_tx.sv
// DShot serial encoder for one motor: builds a 16-bit frame from the
// sampled throttle/telemetry inputs and sends it as pulse-width-coded bits.
// Each frame is followed by a line-low gap.
module dshot_tx #(
  parameter int BIT_CYCLES = 167,
  parameter int T0H_CYCLES = 63,
  parameter int T1H_CYCLES = 125,
  parameter int GAP_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        tlm,
  input  logic [10:0] throttle,
  output logic        dshot_out,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] last_frame
);

  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int CW = $clog2(BIT_CYCLES) + 1;

  typedef enum logic [1:0] {S_GAP, S_LOAD, S_BIT} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] high_len;
  logic [3:0]    bit_idx;
  logic [15:0]   shreg;
  logic [11:0]   v;
  logic [3:0]    crc;
  logic          gap_end, bit_end, frame_end;

  assign gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign bit_end   = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign frame_end = bit_end && (bit_idx == 4'd0);

  // Frame word: a disarmed motor always gets an all-zero frame, tlm included.
  assign v   = arm ? {throttle, tlm} : 12'h000;
  assign crc = v[3:0] ^ v[7:4] ^ v[11:8];

  // Reject illegal timing parameters at the first clock.
  always_ff @(posedge clk) begin
    assert (T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
            T1H_CYCLES < BIT_CYCLES && GAP_CYCLES >= 1)
      else $error("dshot_tx: illegal timing parameters");
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_GAP;
    else     state <= state_nxt;
  end

  // Next state and line outputs; the line is high for the first part of each
  // bit, the length selected by the bit currently at the register MSB.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    dshot_out = 1'b0;
    high_len  = shreg[15] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
    case (state)
      S_GAP:  if (gap_end) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_BIT;
      S_BIT: begin
        busy      = 1'b1;
        dshot_out = (cyc_cnt < high_len);
        if (frame_end) state_nxt = S_GAP;
      end
      default: state_nxt = S_GAP;
    endcase
  end

  // Gap/bit counters, shift register and frame bookkeeping. The gap counter
  // is held at zero outside GAP so every gap starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt    <= '0;
      cyc_cnt    <= '0;
      bit_idx    <= 4'd0;
      shreg      <= 16'h0000;
      last_frame <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == S_BIT) && frame_end;
      case (state)
        S_GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + GW'(1);
        end
        S_LOAD: begin
          gap_cnt    <= '0;
          shreg      <= {v, crc};
          last_frame <= {v, crc};
          bit_idx    <= 4'd15;
          cyc_cnt    <= '0;
        end
        S_BIT: begin
          gap_cnt <= '0;
          if (bit_end) begin
            shreg   <= {shreg[14:0], 1'b0};
            cyc_cnt <= '0;
            bit_idx <= bit_idx - 4'd1;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: gap_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dshot_tx.sv
// Bench for dshot_tx: stimulus pushes expected frame words into a queue,
// a negedge monitor decodes the line and checks each completed frame.
module tb_dshot_tx;

  localparam int BITC = 167;
  localparam int T0H  = 63;
  localparam int T1H  = 125;
  localparam int GAP  = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        tlm = 1'b0;
  logic [10:0] throttle = 11'd0;
  logic        dshot_out, busy, frame_done;
  logic [15:0] last_frame;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  dshot_tx #(.BIT_CYCLES(BITC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
             .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .arm(arm), .tlm(tlm), .throttle(throttle),
    .dshot_out(dshot_out), .busy(busy), .frame_done(frame_done),
    .last_frame(last_frame)
  );

  always #5 clk = ~clk;

  task automatic fail(string name, int act, int exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic chk(string name, int act, int exp);
    if (act != exp) fail(name, act, exp);
    else vectors++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0, hi = 0, nbits = 0, busy_len = 0;
  int          last_rise = 0, rises = 0, last_done = 0;
  bit          period_ok = 0;
  logic        prev_out = 1'b0, prev_done = 1'b0;
  logic [15:0] word = 16'h0;
  logic [15:0] e;

  // Decode pulse widths into bits, then check each frame at frame_done.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      word = 0; nbits = 0; hi = 0; busy_len = 0; rises = 0;
      period_ok = 0; prev_out = 0; prev_done = 0;
    end else begin
      if (dshot_out && !prev_out) begin
        if (rises > 0) chk("bit_spacing", cyc - last_rise, BITC);
        last_rise = cyc;
        rises++;
      end
      if (dshot_out) hi++;
      else if (hi != 0) begin
        if (hi == T1H)      word = {word[14:0], 1'b1};
        else if (hi == T0H) word = {word[14:0], 1'b0};
        else fail("pulse_width", hi, T0H);
        nbits++;
        hi = 0;
      end
      if (busy) busy_len++;
      if (frame_done) begin
        chk("done_one_cycle", int'(prev_done), 0);
        done_cnt++;
        if (exp_q.size() == 0) fail("unexpected_frame", int'(word), 0);
        else begin
          e = exp_q.pop_front();
          chk("frame_bits", int'(word), int'(e));
          chk("last_frame", int'(last_frame), int'(e));
          chk("bit_count", nbits, 16);
          chk("busy_len", busy_len, 16 * BITC);
        end
        if (period_ok) chk("frame_period", cyc - last_done, GAP + 1 + 16 * BITC);
        last_done = cyc;
        period_ok = 1;
        word = 0; nbits = 0; busy_len = 0; rises = 0;
      end
      prev_out  = dshot_out;
      prev_done = frame_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (!frame_done && t < 6000);
    if (!frame_done) fail("frame_done_timeout", t, 6000);
  endtask

  task automatic wait_busy();
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (!busy && t < 6000);
    if (!busy) fail("busy_timeout", t, 6000);
  endtask

  // Cycles from reset release to the first high on the line.
  task automatic first_rise();
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (!dshot_out && t < 3000);
    chk("first_rise", t, GAP + 1);
  endtask

  task automatic set_in(logic a, logic [10:0] th, logic tl, logic [15:0] exp);
    arm = a; throttle = th; tlm = tl;
    exp_q.push_back(exp);
  endtask

  int done_before;

  initial begin
    // Reset state, disarmed
    tick(3);
    chk("rst_dshot_out", int'(dshot_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_last_frame", int'(last_frame), 0);
    rst = 1'b0;
    set_in(1'b0, 11'd1046, 1'b1, 16'h0000);  // disarmed: zero frame regardless
    first_rise();
    wait_done();

    // Armed frames
    set_in(1'b1, 11'd1046, 1'b0, 16'h82C6);
    wait_done();
    set_in(1'b1, 11'd48, 1'b1, 16'h0617);
    wait_done();

    // Input change at bit 8 only affects the following frame
    set_in(1'b1, 11'd1046, 1'b0, 16'h82C6);
    wait_busy();
    tick(8 * BITC + 10);
    set_in(1'b1, 11'd48, 1'b1, 16'h0617);
    wait_done();
    wait_done();

    // All-ones frame
    set_in(1'b1, 11'd2047, 1'b1, 16'hFFFF);
    wait_done();

    // Reset during bit 5: frame is abandoned, fresh frame after a full gap
    exp_q.push_back(16'hFFFF);  // aborted frame; flushed by reset
    wait_busy();
    tick(5 * BITC + 10);
    done_before = done_cnt;
    rst = 1'b1;
    tick(1);
    chk("abort_dshot_out", int'(dshot_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_last_frame", int'(last_frame), 0);
    rst = 1'b0;
    exp_q.push_back(16'hFFFF);
    first_rise();
    chk("no_done_on_abort", done_cnt, done_before);
    wait_done();
    tick(2);
    chk("done_after_abort", done_cnt, done_before + 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
